data_fifo_burst_reader: RTL and testbench

//  Downstream drain stage for data_fifo_control. Accepts a burst request of
//  `length` beats and waits until the FIFO holds the whole burst. It then pops

---
 rtl/nvme_pkg.sv | 15 +
 rtl/data_fifo_burst_reader.sv | 116 +++++++++++
 tb/tb_data_fifo_burst_reader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nvme_pkg.sv
// Shared constants and state encoding for the NVMe/DDR write-path drain logic.
package nvme_pkg;

  localparam int unsigned MAX_BEATS    = 256;
  localparam int unsigned FIFO_COUNT_W = 14;
  localparam int unsigned LEN_W        = 9;

  typedef enum logic [3:0] {
    S_IDLE      = 4'b0001,
    S_WAIT      = 4'b0010,
    S_READ_DATA = 4'b0100,
    S_READ_DONE = 4'b1000
  } rd_state_e;

endpackage

// File: rtl/data_fifo_burst_reader.sv
// Drains a full burst from an FWFT data FIFO into a registered AXI-Stream
// write-data master once the FIFO holds every beat of the burst.
module data_fifo_burst_reader
  import nvme_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned MAX_BEATS  = nvme_pkg::MAX_BEATS
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    read_req,
  input  logic [LEN_W-1:0]        length,
  output logic                    req_ready,
  output logic                    len_err,
  output logic                    transfer_done,
  output logic                    busy,
  output logic                    fifo_pop,
  input  logic [DATA_WIDTH-1:0]   data_from_fifo,
  input  logic                    fifo_empty,
  input  logic [FIFO_COUNT_W-1:0] data_count,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BEATS);

  rd_state_e        state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] pop_cnt;
  logic [LEN_W-1:0] beat_cnt;
  logic             handshake;
  logic             len_ok;
  logic             burst_avail;

  assign handshake   = m_axis_tvalid & m_axis_tready;
  assign len_ok      = (length != '0) && (length <= MAX_LEN);
  assign burst_avail = data_count >= {{(FIFO_COUNT_W-LEN_W){1'b0}}, len_q};

  // A pop may only land in the output register when it is empty or draining.
  assign fifo_pop = (state == S_READ_DATA) && (!m_axis_tvalid || m_axis_tready) &&
                    !fifo_empty && (pop_cnt < len_q);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= S_IDLE;
      len_q         <= '0;
      pop_cnt       <= '0;
      beat_cnt      <= '0;
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      len_err       <= 1'b0;
      transfer_done <= 1'b0;
    end else begin
      len_err       <= 1'b0;
      transfer_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (read_req) begin
            if (len_ok) begin
              len_q     <= length;
              pop_cnt   <= '0;
              beat_cnt  <= '0;
              state     <= S_WAIT;
              req_ready <= 1'b0;
              busy      <= 1'b1;
            end else begin
              len_err <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (burst_avail) state <= S_READ_DATA;
        end
        S_READ_DATA: begin
          if (fifo_pop) pop_cnt <= pop_cnt + 1'b1;
          if (handshake) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt + 1'b1 == len_q) begin
              state         <= S_READ_DONE;
              transfer_done <= 1'b1;
            end
          end
        end
        S_READ_DONE: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Output register holds steady while stalled, since fifo_pop is blocked then.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (fifo_pop) begin
      m_axis_tdata  <= data_from_fifo;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= (pop_cnt == len_q - 1'b1);
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_fifo_burst_reader.sv
// Randomised bench for data_fifo_burst_reader with an FWFT FIFO model and a
// word-order scoreboard.
module tb_data_fifo_burst_reader;
  import nvme_pkg::*;

  localparam int DW = 128;

  logic                    aclk = 1'b0;
  logic                    aresetn;
  logic                    read_req;
  logic [LEN_W-1:0]        length;
  logic                    req_ready, len_err, transfer_done, busy, fifo_pop;
  logic [DW-1:0]           data_from_fifo = '0;
  logic                    fifo_empty = 1'b1;
  logic [FIFO_COUNT_W-1:0] data_count = '0;
  logic [DW-1:0]           m_axis_tdata;
  logic                    m_axis_tvalid, m_axis_tlast;
  logic                    m_axis_tready;

  data_fifo_burst_reader #(.DATA_WIDTH(DW), .MAX_BEATS(256)) dut (
    .aclk(aclk), .aresetn(aresetn), .read_req(read_req), .length(length),
    .req_ready(req_ready), .len_err(len_err), .transfer_done(transfer_done),
    .busy(busy), .fifo_pop(fifo_pop), .data_from_fifo(data_from_fifo),
    .fifo_empty(fifo_empty), .data_count(data_count),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Physical FIFO (what the DUT sees) and reference word stream (what must come out).
  logic [DW-1:0] fq[$];
  logic [DW-1:0] push_pend[$];
  logic [DW-1:0] model_q[$];
  int            pop_total = 0;

  always @(posedge aclk) begin
    if (fifo_pop && fq.size() > 0) begin
      void'(fq.pop_front());
      pop_total <= pop_total + 1;
    end
    while (push_pend.size() > 0) fq.push_back(push_pend.pop_front());
    data_from_fifo <= (fq.size() > 0) ? fq[0] : '0;
    fifo_empty     <= (fq.size() == 0);
    data_count     <= FIFO_COUNT_W'(fq.size());
  end

  task automatic push(input logic [DW-1:0] w);
    push_pend.push_back(w);
    model_q.push_back(w);
  endtask

  // Sink ready generator: 0 = always ready, 1 = random, 2 = fixed toggle pattern.
  int   rdy_mode = 0;
  logic pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  initial begin
    int pi = 0;
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      case (rdy_mode)
        1: m_axis_tready = 1'($urandom_range(0, 1));
        2: begin
          if (m_axis_tvalid && pi < 7) begin
            m_axis_tready = pat[pi];
            pi++;
          end else m_axis_tready = 1'b1;
        end
        default: m_axis_tready = 1'b1;
      endcase
    end
  end

  // Scoreboard: every handshake must carry the next expected word.
  int            beat_idx = 0, exp_len = 0, done_cnt = 0, cyc = 0;
  int            first_cyc = 0, last_cyc = 0;
  logic          done_exp = 1'b0, stall_prev = 1'b0, hold_last;
  logic [DW-1:0] hold_data, exp_w;

  always @(negedge aclk) begin
    cyc++;
    if (!aresetn) begin
      beat_idx = 0; done_exp = 1'b0; stall_prev = 1'b0;
    end else begin
      if (done_exp || transfer_done) begin
        check_val("transfer_done", transfer_done, done_exp);
        if (transfer_done) done_cnt++;
      end
      done_exp = 1'b0;
      if (stall_prev) begin
        check_val("stall_tvalid", m_axis_tvalid, 1);
        check_val("stall_tdata", m_axis_tdata, hold_data);
        check_val("stall_tlast", m_axis_tlast, hold_last);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check_val("model_nonempty", DW'(model_q.size() > 0), 1);
        if (model_q.size() > 0) begin
          exp_w = model_q.pop_front();
          check_val("tdata", m_axis_tdata, exp_w);
        end
        check_val("tlast", m_axis_tlast, DW'(beat_idx == exp_len - 1));
        if (beat_idx == 0) first_cyc = cyc;
        beat_idx++;
        if (beat_idx == exp_len) begin
          done_exp = 1'b1; last_cyc = cyc; beat_idx = 0;
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      hold_data  = m_axis_tdata;
      hold_last  = m_axis_tlast;
    end
  end

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic request(input int len);
    int n = 0;
    while (!req_ready && n < 3000) begin tick(); n++; end
    check_val("req_ready_wait", DW'(n < 3000), 1);
    if (len >= 1 && len <= 256) exp_len = len;
    read_req = 1'b1;
    length   = LEN_W'(len);
    tick();
    read_req = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    int n = 0;
    while (done_cnt == base && n < budget) begin tick(); n++; end
    check_val("done_timeout", DW'(n < budget), 1);
    check_val("idle_ready", req_ready, 1);
    check_val("idle_busy", busy, 0);
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_req_ready"}, req_ready, 1);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_len_err"}, len_err, 0);
    check_val({tag, "_done"}, transfer_done, 0);
    check_val({tag, "_pop"}, fifo_pop, 0);
    check_val({tag, "_tvalid"}, m_axis_tvalid, 0);
    check_val({tag, "_tlast"}, m_axis_tlast, 0);
    check_val({tag, "_tdata"}, m_axis_tdata, 0);
  endtask

  initial begin
    int base, p0, len, pre, n;
    aresetn  = 1'b0;
    read_req = 1'b0;
    length   = '0;
    #12;
    check_reset_outs("rst");
    aresetn = 1'b1;
    tick(); tick();

    // 1: sixteen preloaded words at full rate
    for (int i = 0; i < 16; i++) push(DW'(i));
    tick(); tick();
    base = done_cnt; p0 = pop_total;
    request(16);
    wait_done(base, 200);
    check_val("t1_span", DW'(last_cyc - first_cyc), 15);
    check_val("t1_pops", DW'(pop_total - p0), 16);

    // 2: not enough data yet, must hold in wait without popping
    for (int i = 0; i < 3; i++) push(DW'(32'hA000 + i));
    tick(); tick();
    base = done_cnt; p0 = pop_total;
    request(8);
    repeat (10) tick();
    check_val("t2_wait_pops", DW'(pop_total - p0), 0);
    check_val("t2_wait_busy", busy, 1);
    check_val("t2_wait_ready", req_ready, 0);
    check_val("t2_wait_tvalid", m_axis_tvalid, 0);
    for (int i = 3; i < 8; i++) push(DW'(32'hA000 + i));
    wait_done(base, 200);
    check_val("t2_pops", DW'(pop_total - p0), 8);

    // 3: illegal lengths
    p0 = pop_total;
    request(0);
    check_val("t3_err0", len_err, 1);
    check_val("t3_ready0", req_ready, 1);
    tick();
    check_val("t3_err0_clr", len_err, 0);
    request(300);
    check_val("t3_err300", len_err, 1);
    check_val("t3_busy300", busy, 0);
    tick();
    check_val("t3_err300_clr", len_err, 0);
    repeat (5) tick();
    check_val("t3_pops", DW'(pop_total - p0), 0);
    check_val("t3_ready", req_ready, 1);

    // 4: stalled sink with a fixed ready pattern
    for (int i = 0; i < 4; i++) push({$urandom, $urandom, $urandom, $urandom});
    tick(); tick();
    base = done_cnt; p0 = pop_total;
    rdy_mode = 2;
    request(4);
    wait_done(base, 200);
    check_val("t4_pops", DW'(pop_total - p0), 4);
    rdy_mode = 0;

    // 5: maximum length burst
    for (int i = 0; i < 256; i++) push(DW'(32'h10000 + i));
    tick(); tick();
    check_val("t5_count", data_count, 256);
    base = done_cnt; p0 = pop_total;
    request(256);
    wait_done(base, 2000);
    check_val("t5_pops", DW'(pop_total - p0), 256);
    check_val("t5_span", DW'(last_cyc - first_cyc), 255);

    // 6: reset in the middle of a burst, then a fresh short burst
    for (int i = 0; i < 10; i++) push(DW'(32'hB000 + i));
    tick(); tick();
    request(10);
    n = 0;
    while (beat_idx < 5 && n < 200) begin tick(); n++; end
    check_val("t6_reach_beat5", DW'(n < 200), 1);
    aresetn = 1'b0;
    #1;
    check_reset_outs("t6_rst");
    tick();
    aresetn = 1'b1;
    model_q = fq;
    foreach (push_pend[i]) model_q.push_back(push_pend[i]);
    tick();
    base = done_cnt; p0 = pop_total;
    request(2);
    wait_done(base, 200);
    check_val("t6_pops", DW'(pop_total - p0), 2);

    // random bursts, random ready, late-arriving data, requests while busy
    for (int it = 0; it < 10; it++) begin
      len = int'($urandom_range(1, 48));
      pre = int'($urandom_range(0, len));
      for (int k = 0; k < pre; k++) push({$urandom, $urandom, $urandom, $urandom});
      rdy_mode = int'($urandom_range(0, 1));
      base = done_cnt; p0 = pop_total;
      request(len);
      read_req = 1'b1;
      length   = '0;
      tick();
      read_req = 1'b0;
      check_val("rnd_busy_req_err", len_err, 0);
      for (int k = pre; k < len; k++) begin
        repeat ($urandom_range(0, 3)) tick();
        push({$urandom, $urandom, $urandom, $urandom});
      end
      wait_done(base, 3000);
      check_val("rnd_pops", DW'(pop_total - p0), DW'(len));
    end
    rdy_mode = 0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
